// File: rtl/multicycle_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS main control FSM and the
// datapath blocks it steers (ALU input-B mux, ALU funct decoder, PC mux).
//   - state_t     : FSM state encodings (12 of 16 codes used)
//   - OP_*        : instr[31:26] opcodes understood by the controller
//   - SRCB_*      : ALU input-B select codes, shared with the input-B mux
//   - ALUOP_*     : alu_op codes consumed by the ALU funct decoder
//   - PCSRC_*     : next-PC mux select codes
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    localparam int STATE_W_DEF = 4;
    localparam int OPCODE_W    = 6;

    typedef enum logic [STATE_W_DEF-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REG   = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm_if
// Bundle between the main control FSM and the multicycle datapath.
//   Datapath -> controller : opcode (instr[31:26]), zero (ALU zero flag)
//   Controller -> datapath : pc_en, iord, mem_write, ir_write, reg_dst,
//                            mem_to_reg, reg_write, alu_src_a, alu_src_b,
//                            alu_op, pc_src, illegal_op, state_dbg
// modport master : the controller side
// modport slave  : the datapath side
// ---------------------------------------------------------------------------
interface multicycle_control_fsm_if
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                pc_en;
    logic                iord;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          pc_src;
    logic                illegal_op;
    logic [STATE_W-1:0]  state_dbg;

    modport master (
        input  opcode, zero,
        output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
               illegal_op, state_dbg
    );

    modport slave (
        output opcode, zero,
        input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
               illegal_op, state_dbg
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
// Main control state machine of the multicycle 32-bit MIPS datapath.
// Moore decode of every datapath select/enable from the registered state;
// pc_en additionally uses zero (branch) and illegal_op uses opcode (decode).
// Ports:
//   clk   : rising-edge system clock
//   reset : asynchronous, active-high; forces FETCH and masks all enables
//   bus   : multicycle_control_fsm_if.master (opcode/zero in, controls out)
// ---------------------------------------------------------------------------
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_control_fsm_if.master bus
);

    state_t r_state;
    state_t w_next_state;

    // Raw (ungated) decode of the current state
    logic       w_pc_write;
    logic       w_branch;
    logic       w_iord;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_src;
    logic       w_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_iord       = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = SRCB_REG;
        w_alu_op     = ALUOP_ADD;
        w_pc_src     = PCSRC_ALU;
        w_illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_alu_src_b  = SRCB_FOUR;
                w_pc_write   = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut
                w_alu_src_b = SRCB_IMMSH;
                case (bus.opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEXEC;
                    OP_J:         w_next_state = S_JUMP;
                    default: begin
                        w_next_state = S_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
                // Only lw/sw reach this state; anything else just refetches
                if (bus.opcode == OP_LW) begin
                    w_next_state = S_MEMREAD;
                end else if (bus.opcode == OP_SW) begin
                    w_next_state = S_MEMWRITE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_MEMREAD: begin
                w_iord       = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTE: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_REG;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_REG;
                w_alu_op    = ALUOP_SUB;
                w_pc_src    = PCSRC_ALUOUT;
                w_branch    = 1'b1;
            end
            S_ADDIEXEC: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_IMM;
                w_next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
            end
            S_JUMP: begin
                w_pc_src   = PCSRC_JUMP;
                w_pc_write = 1'b1;
            end
            default: begin
                // Unused encodings: all outputs at defaults, recover to FETCH
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Enables are masked by reset directly so nothing is written in the
    // cycle reset rises, even before the state register has been cleared.
    assign bus.pc_en      = ~reset & (w_pc_write | (w_branch & bus.zero));
    assign bus.mem_write  = ~reset & w_mem_write;
    assign bus.ir_write   = ~reset & w_ir_write;
    assign bus.reg_write  = ~reset & w_reg_write;
    assign bus.illegal_op = ~reset & w_illegal;

    assign bus.iord       = w_iord;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.alu_op     = w_alu_op;
    assign bus.pc_src     = w_pc_src;
    assign bus.state_dbg  = STATE_W'(r_state);

endmodule
